rc4_prga_decrypt: RTL and testbench

RC4_PRGA_DECRYPT -- requirements
Module: rc4_prga_decrypt

---
 rtl/rc4_prga_decrypt_pkg.sv | 36 +++
 rtl/rc4_prga_decrypt_if.sv | 25 ++
 rtl/rc4_prga_decrypt_datapath.sv | 85 ++++++++
 rtl/rc4_prga_decrypt.sv | 101 ++++++++++
 tb/tb_rc4_prga_decrypt.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rc4_prga_decrypt_pkg.sv
// rtl/rc4_prga_decrypt_pkg.sv - shared types and sizes for the RC4 PRGA decrypt block
package rc4_pkg;

  localparam int MSG_LEN_DEFAULT = 32;
  localparam int S_AW            = 8;
  localparam int MSG_AW          = 5;

  typedef enum logic [3:0] {
    IDLE,
    RD_SI,
    WAIT_SI,
    CAP_SI,
    RD_SJ,
    WAIT_SJ,
    CAP_SJ,
    WR_SI,
    WR_SJ,
    RD_F,
    WAIT_F,
    CAP_F,
    WR_D,
    DONE
  } state_t;

  // One-hot datapath load enables; each is high in exactly one FSM state.
  typedef struct packed {
    logic ld_start;
    logic cap_si;
    logic cap_sj;
    logic wr_si;
    logic wr_sj;
    logic cap_f;
    logic nxt_byte;
  } dp_ctrl_t;

endpackage

// File: rtl/rc4_prga_decrypt_if.sv
// rtl/rc4_prga_decrypt_if.sv - S-array, message ROM and result RAM bus
interface rc4_prga_decrypt_if;
  import rc4_pkg::*;

  logic [S_AW-1:0]   s_addr;
  logic [7:0]        s_wr_data;
  logic              s_wren;
  logic [7:0]        s_q;
  logic [MSG_AW-1:0] m_addr;
  logic [7:0]        m_q;
  logic [MSG_AW-1:0] d_addr;
  logic [7:0]        d_data;
  logic              d_wren;

  modport master (
    output s_addr, s_wr_data, s_wren, m_addr, d_addr, d_data, d_wren,
    input  s_q, m_q
  );

  modport slave (
    input  s_addr, s_wr_data, s_wren, m_addr, d_addr, d_data, d_wren,
    output s_q, m_q
  );

endinterface

// File: rtl/rc4_prga_decrypt_datapath.sv
// rtl/rc4_prga_decrypt_datapath.sv - index/byte registers and registered address/data outputs
module rc4_prga_datapath
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  dp_ctrl_t          i_ctrl,
  input  logic [7:0]        i_s_q,
  input  logic [7:0]        i_m_q,
  output logic [S_AW-1:0]   o_s_addr,
  output logic [7:0]        o_s_wr_data,
  output logic [MSG_AW-1:0] o_m_addr,
  output logic [MSG_AW-1:0] o_d_addr,
  output logic [7:0]        o_d_data,
  output logic              o_last
);

  logic [7:0]        r_i, r_j, r_si, r_sj, r_f;
  logic [MSG_AW-1:0] r_k, r_m_addr, r_d_addr;
  logic [S_AW-1:0]   r_s_addr;
  logic [7:0]        r_s_wr_data;
  logic [7:0]        w_j_nxt;

  assign w_j_nxt     = r_j + i_s_q;
  assign o_s_addr    = r_s_addr;
  assign o_s_wr_data = r_s_wr_data;
  assign o_m_addr    = r_m_addr;
  assign o_d_addr    = r_d_addr;
  assign o_d_data    = r_f;
  assign o_last      = (r_k == MSG_AW'(MSG_LEN - 1));

  // Outputs are loaded one state early so each address is already stable when its state begins
  // and stays put until the next load; the swap only ever uses the captured si/sj.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_si        <= '0;
      r_sj        <= '0;
      r_f         <= '0;
      r_s_addr    <= '0;
      r_s_wr_data <= '0;
      r_m_addr    <= '0;
      r_d_addr    <= '0;
    end else begin
      if (i_ctrl.ld_start) begin
        r_i      <= 8'd1;
        r_j      <= 8'd0;
        r_k      <= '0;
        r_s_addr <= 8'd1;
      end
      if (i_ctrl.cap_si) begin
        r_si     <= i_s_q;
        r_j      <= w_j_nxt;
        r_s_addr <= w_j_nxt;
      end
      if (i_ctrl.cap_sj) begin
        r_sj        <= i_s_q;
        r_s_addr    <= r_i;
        r_s_wr_data <= i_s_q;
      end
      if (i_ctrl.wr_si) begin
        r_s_addr    <= r_j;
        r_s_wr_data <= r_si;
      end
      if (i_ctrl.wr_sj) begin
        r_s_addr <= r_si + r_sj;
        r_m_addr <= r_k;
      end
      if (i_ctrl.cap_f) begin
        r_f      <= i_s_q ^ i_m_q;
        r_d_addr <= r_k;
      end
      if (i_ctrl.nxt_byte) begin
        r_i      <= r_i + 8'd1;
        r_k      <= r_k + 1'b1;
        r_s_addr <= r_i + 8'd1;
      end
    end
  end

endmodule

// File: rtl/rc4_prga_decrypt.sv
// rtl/rc4_prga_decrypt.sv - RC4 keystream generation and XOR decrypt of a stored message
module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                finish,
  rc4_prga_decrypt_if.master  bus
);

  state_t   r_state, w_state_nxt;
  dp_ctrl_t w_ctrl;
  logic     w_s_wren, w_d_wren, w_finish, w_last;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state, strobes and datapath enables; each byte walks RD_SI..WR_D in 12 cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_ctrl      = '0;
    w_s_wren    = 1'b0;
    w_d_wren    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_ctrl.ld_start = 1'b1;
          w_state_nxt     = RD_SI;
        end
      end
      RD_SI:   w_state_nxt = WAIT_SI;
      WAIT_SI: w_state_nxt = CAP_SI;
      CAP_SI: begin
        w_ctrl.cap_si = 1'b1;
        w_state_nxt   = RD_SJ;
      end
      RD_SJ:   w_state_nxt = WAIT_SJ;
      WAIT_SJ: w_state_nxt = CAP_SJ;
      CAP_SJ: begin
        w_ctrl.cap_sj = 1'b1;
        w_state_nxt   = WR_SI;
      end
      WR_SI: begin
        w_s_wren     = 1'b1;
        w_ctrl.wr_si = 1'b1;
        w_state_nxt  = WR_SJ;
      end
      WR_SJ: begin
        w_s_wren     = 1'b1;
        w_ctrl.wr_sj = 1'b1;
        w_state_nxt  = RD_F;
      end
      RD_F:   w_state_nxt = WAIT_F;
      WAIT_F: w_state_nxt = CAP_F;
      CAP_F: begin
        w_ctrl.cap_f = 1'b1;
        w_state_nxt  = WR_D;
      end
      WR_D: begin
        w_d_wren = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_ctrl.nxt_byte = 1'b1;
          w_state_nxt     = RD_SI;
        end
      end
      DONE: begin
        w_finish = 1'b1;
        if (!start) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.s_wren = w_s_wren & ~reset;
  assign bus.d_wren = w_d_wren & ~reset;
  assign finish     = w_finish & ~reset;

  rc4_prga_datapath #(.MSG_LEN(MSG_LEN)) u_datapath (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_ctrl      (w_ctrl),
    .i_s_q       (bus.s_q),
    .i_m_q       (bus.m_q),
    .o_s_addr    (bus.s_addr),
    .o_s_wr_data (bus.s_wr_data),
    .o_m_addr    (bus.m_addr),
    .o_d_addr    (bus.d_addr),
    .o_d_data    (bus.d_data),
    .o_last      (w_last)
  );

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// tb/tb_rc4_prga_decrypt.sv - directed self-checking bench for rc4_prga_decrypt
module tb_rc4_prga_decrypt;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic finish;
  logic load_req = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] s_init [256];
  logic [7:0] m_init [32];
  logic [7:0] exp_d  [32];
  logic [7:0] key_d  [32];
  logic [7:0] s_mem  [256];
  logic [7:0] m_mem  [32];
  logic [7:0] d_mem  [32];
  logic [7:0] snap   [256];
  logic [7:0] s_q_r, m_q_r;
  int s_wr_cnt, d_wr_cnt;

  always #5 clk = ~clk;

  rc4_prga_decrypt_if bus();

  rc4_prga_decrypt #(.MSG_LEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .finish (finish),
    .bus    (bus)
  );

  assign bus.s_q = s_q_r;
  assign bus.m_q = m_q_r;

  // Memories with one-cycle registered read.
  always @(posedge clk) begin
    if (load_req) begin
      for (int n = 0; n < 256; n++) s_mem[n] <= s_init[n];
      for (int n = 0; n < 32; n++) begin
        m_mem[n] <= m_init[n];
        d_mem[n] <= 8'h00;
      end
      s_wr_cnt <= 0;
      d_wr_cnt <= 0;
    end else begin
      if (bus.s_wren) begin
        s_mem[bus.s_addr] <= bus.s_wr_data;
        s_wr_cnt <= s_wr_cnt + 1;
      end
      if (bus.d_wren) begin
        d_mem[bus.d_addr] <= bus.d_data;
        d_wr_cnt <= d_wr_cnt + 1;
        if (bus.d_addr == 5'd2)
          for (int n = 0; n < 256; n++) snap[n] <= s_mem[n];
      end
    end
    s_q_r <= s_mem[bus.s_addr];
    m_q_r <= m_mem[bus.m_addr];
  end

  task automatic preload();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic model_prga();
    logic [7:0] s [256];
    logic [7:0] i, j, t, ix;
    for (int n = 0; n < 256; n++) s[n] = s_init[n];
    i = 0; j = 0;
    for (int k = 0; k < 32; k++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      ix = s[i] + s[j];
      exp_d[k] = s[ix] ^ m_init[k];
    end
  endtask

  task automatic ksa_key();
    logic [7:0] key [3];
    logic [7:0] j, t;
    key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
    for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = j + s_init[n] + key[n % 3];
      t = s_init[n]; s_init[n] = s_init[j]; s_init[j] = t;
    end
  endtask

  task automatic run_start(output int fin_cyc);
    start = 1'b1;
    fin_cyc = -1;
    for (int c = 1; c <= 500 && fin_cyc < 0; c++) begin
      @(posedge clk); #1;
      if (finish === 1'b1) fin_cyc = c;
    end
  endtask

  task automatic run_decrypt(input string tag);
    int fc;
    run_start(fc);
    n_checks++;
    if (fc !== 385) begin
      n_fail++;
      $display("FAIL %s_finish_cycle: got %0d expected 385", tag, fc);
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_full(input string tag);
    for (int k = 0; k < 32; k++) begin
      n_checks++;
      if (d_mem[k] !== exp_d[k]) begin
        n_fail++;
        $display("FAIL %s_d[%0d]: got %h expected %h", tag, k, d_mem[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({finish, bus.s_wren, bus.d_wren} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 000", {finish, bus.s_wren, bus.d_wren});
    end
    n_checks++;
    if ({bus.s_addr, bus.s_wr_data, bus.m_addr, bus.d_addr, bus.d_data} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {bus.s_addr, bus.s_wr_data, bus.m_addr, bus.d_addr, bus.d_data});
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_identity();
    logic [7:0] hand [3];
    hand[0] = 8'h02; hand[1] = 8'h05; hand[2] = 8'h07;
    for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
    for (int n = 0; n < 32; n++) m_init[n] = 8'h00;
    model_prga();
    preload();
    run_decrypt("identity");
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (d_mem[k] !== hand[k]) begin
        n_fail++;
        $display("FAIL identity_hand_d[%0d]: got %h expected %h", k, d_mem[k], hand[k]);
      end
    end
    n_checks++;
    if ({snap[1], snap[2], snap[3], snap[5]} !== {8'd1, 8'd3, 8'd5, 8'd2}) begin
      n_fail++;
      $display("FAIL identity_s_after_3: got %h expected 01030502",
               {snap[1], snap[2], snap[3], snap[5]});
    end
    n_checks++;
    if (s_wr_cnt !== 64 || d_wr_cnt !== 32) begin
      n_fail++;
      $display("FAIL identity_write_counts: got %0d/%0d expected 64/32", s_wr_cnt, d_wr_cnt);
    end
    check_full("identity");
  endtask

  task automatic test_reversed();
    for (int n = 0; n < 256; n++) s_init[n] = 8'(255 - n);
    for (int n = 0; n < 32; n++) m_init[n] = 8'hFF;
    model_prga();
    preload();
    run_decrypt("reversed");
    n_checks++;
    if ({d_mem[0], d_mem[1]} !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL reversed_wrap: got %h expected fffe", {d_mem[0], d_mem[1]});
    end
    check_full("reversed");
  endtask

  task automatic test_key();
    logic [39:0] got;
    ksa_key();
    for (int n = 0; n < 32; n++) m_init[n] = 8'h00;
    model_prga();
    preload();
    run_decrypt("key");
    got = {d_mem[0], d_mem[1], d_mem[2], d_mem[3], d_mem[4]};
    n_checks++;
    if (got !== 40'hEB9F7781B7) begin
      n_fail++;
      $display("FAIL key_first5: got %h expected eb9f7781b7", got);
    end
    check_full("key");
    for (int k = 0; k < 32; k++) key_d[k] = d_mem[k];
  endtask

  task automatic test_start_hold();
    int fc, sw, dw;
    bit held;
    preload();
    run_start(fc);
    n_checks++;
    if (fc !== 385) begin
      n_fail++;
      $display("FAIL hold_finish_cycle: got %0d expected 385", fc);
    end
    sw = s_wr_cnt; dw = d_wr_cnt;
    held = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (finish !== 1'b1 || bus.s_wren !== 1'b0 || bus.d_wren !== 1'b0) held = 1'b0;
    end
    n_checks++;
    if (!held || s_wr_cnt !== sw || d_wr_cnt !== dw) begin
      n_fail++;
      $display("FAIL hold_done_quiet: got held=%0b writes %0d/%0d expected 1 %0d/%0d",
               held, s_wr_cnt, d_wr_cnt, sw, dw);
    end
    start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (finish !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_drop_start: got finish=%b expected 0", finish);
    end
    preload();
    run_decrypt("rerun");
    for (int k = 0; k < 32; k++) begin
      n_checks++;
      if (d_mem[k] !== key_d[k]) begin
        n_fail++;
        $display("FAIL rerun_d[%0d]: got %h expected %h", k, d_mem[k], key_d[k]);
      end
    end
  endtask

  task automatic test_abort();
    preload();
    start = 1'b1;
    repeat (126) @(posedge clk);
    #1;
    n_checks++;
    if (s_wr_cnt !== 20 || d_wr_cnt !== 10) begin
      n_fail++;
      $display("FAIL abort_pre_counts: got %0d/%0d expected 20/10", s_wr_cnt, d_wr_cnt);
    end
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({finish, bus.s_wren, bus.d_wren} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_strobes: got %b expected 000", {finish, bus.s_wren, bus.d_wren});
    end
    n_checks++;
    if (bus.s_addr !== 8'h00 || bus.d_addr !== 5'h00) begin
      n_fail++;
      $display("FAIL abort_addr: got %h/%h expected 00/00", bus.s_addr, bus.d_addr);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    preload();
    run_decrypt("after_abort");
    for (int k = 0; k < 32; k++) begin
      n_checks++;
      if (d_mem[k] !== key_d[k]) begin
        n_fail++;
        $display("FAIL after_abort_d[%0d]: got %h expected %h", k, d_mem[k], key_d[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_reversed();
    test_key();
    test_start_hold();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
